// File: rtl/axi_wr_burst_master.sv
// AXI4 write-burst master: accepts one burst command, issues the AW beat,
// streams user beats onto W with zero latency, waits for B and pulses done.
// Optional feature macro: AXI_WR_BRESP_CHECK_EN makes err a sticky flag that
// is set by a non-OKAY bresp or a bid that does not match the issued id.
//
//  state  | meaning
//  IDLE   | cmd_ready high, waiting for a burst command
//  ADDR   | AW beat presented, waiting for awready
//  DATA   | user beats forwarded to W until the wlast handshake
//  RESP   | bready high, waiting for the write response
//  DONE   | one-cycle completion pulse
module axi_wr_burst_master #(
   parameter int IDW = 4,
   parameter int AW  = 32,
   parameter int DW  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     cmd_addr,
   input  logic [7:0]        cmd_len,
   input  logic [2:0]        cmd_size,
   input  logic [1:0]        cmd_burst,
   input  logic [IDW-1:0]    cmd_id,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DW-1:0]     wr_data,
   input  logic [DW/8-1:0]   wr_strb,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [IDW-1:0]    m_axi_awid,
   output logic [AW-1:0]     m_axi_awaddr,
   output logic [7:0]        m_axi_awlen,
   output logic [2:0]        m_axi_awsize,
   output logic [1:0]        m_axi_awburst,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [DW-1:0]     m_axi_wdata,
   output logic [DW/8-1:0]   m_axi_wstrb,
   output logic              m_axi_wlast,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   input  logic [IDW-1:0]    m_axi_bid,
   input  logic [1:0]        m_axi_bresp,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,
   output logic              done,
   output logic [1:0]        resp,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_RESP = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [IDW-1:0] tx_id;
   logic [7:0]     beat_cnt;
   logic           last_beat;
   logic           w_hs;

   assign last_beat = (beat_cnt == m_axi_awlen);
   assign w_hs      = (state == S_DATA) && wr_valid && m_axi_wready;

   // W payload is a straight pass-through; only the handshake is gated
   assign m_axi_wdata = wr_data;
   assign m_axi_wstrb = wr_strb;
   assign m_axi_awid  = tx_id;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (cmd_valid)            state_nx = S_ADDR;
         S_ADDR: if (m_axi_awready)        state_nx = S_DATA;
         S_DATA: if (w_hs && last_beat)    state_nx = S_RESP;
         S_RESP: if (m_axi_bvalid)         state_nx = S_DONE;
         S_DONE:                           state_nx = S_IDLE;
         default:                          state_nx = S_IDLE;
      endcase
   end

   // handshake outputs decoded from the current state
   always_comb begin
      cmd_ready     = (state == S_IDLE);
      m_axi_awvalid = (state == S_ADDR);
      m_axi_wvalid  = (state == S_DATA) && wr_valid;
      wr_ready      = (state == S_DATA) && m_axi_wready;
      m_axi_wlast   = (state == S_DATA) && last_beat;
      m_axi_bready  = (state == S_RESP);
      done          = (state == S_DONE);
   end

   // AW payload capture, beat counting and response capture
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_id         <= '0;
         m_axi_awaddr  <= '0;
         m_axi_awlen   <= '0;
         m_axi_awsize  <= '0;
         m_axi_awburst <= '0;
         beat_cnt      <= '0;
         resp          <= '0;
      end else begin
         if (state == S_IDLE && cmd_valid) begin
            tx_id         <= cmd_id;
            m_axi_awaddr  <= cmd_addr;
            m_axi_awlen   <= cmd_len;
            m_axi_awsize  <= cmd_size;
            m_axi_awburst <= cmd_burst;
         end
         if (state == S_ADDR && m_axi_awready)
            beat_cnt <= '0;
         else if (w_hs && !last_beat)
            beat_cnt <= beat_cnt + 8'd1;
         if (state == S_RESP && m_axi_bvalid)
            resp <= m_axi_bresp;
      end
   end

`ifdef AXI_WR_BRESP_CHECK_EN
   // sticky error: bad response code or response id not matching the burst
   always_ff @(posedge clk) begin
      if (rst)
         err <= 1'b0;
      else if (state == S_RESP && m_axi_bvalid &&
               (m_axi_bresp != 2'b00 || m_axi_bid != tx_id))
         err <= 1'b1;
   end
`else
   wire unused_bid = ^m_axi_bid;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Directed bench for axi_wr_burst_master with a transaction-phase model and
// per-cycle output comparison, plus literal expectations per scenario.
module tb_axi_wr_burst_master;
   localparam int IDW = 4;
   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int SW  = DW/8;
`ifdef AXI_WR_BRESP_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   localparam int P_IDLE = 0, P_ADDR = 1, P_DATA = 2, P_RESP = 3, P_DONE = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [AW-1:0]  cmd_addr;
   logic [7:0]     cmd_len;
   logic [2:0]     cmd_size;
   logic [1:0]     cmd_burst;
   logic [IDW-1:0] cmd_id;
   logic           cmd_valid;
   logic           cmd_ready;
   logic [DW-1:0]  wr_data;
   logic [SW-1:0]  wr_strb;
   logic           wr_valid;
   logic           wr_ready;
   logic [IDW-1:0] m_axi_awid;
   logic [AW-1:0]  m_axi_awaddr;
   logic [7:0]     m_axi_awlen;
   logic [2:0]     m_axi_awsize;
   logic [1:0]     m_axi_awburst;
   logic           m_axi_awvalid;
   logic           m_axi_awready;
   logic [DW-1:0]  m_axi_wdata;
   logic [SW-1:0]  m_axi_wstrb;
   logic           m_axi_wlast;
   logic           m_axi_wvalid;
   logic           m_axi_wready;
   logic [IDW-1:0] m_axi_bid;
   logic [1:0]     m_axi_bresp;
   logic           m_axi_bvalid;
   logic           m_axi_bready;
   logic           done;
   logic [1:0]     resp;
   logic           err;

   axi_wr_burst_master #(.IDW(IDW), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
      .cmd_burst(cmd_burst), .cmd_id(cmd_id), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .done(done), .resp(resp), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      total++;
      bad++;
      $display("FAIL %s timeout actual=expired expected=handshake at %0t", nm, $time);
   endtask

   // model state: burst phase plus captured command and beat bookkeeping
   bit             en = 1'b0;
   int             ph = P_IDLE;
   logic [7:0]     m_len, m_cnt;
   logic [AW-1:0]  m_addr;
   logic [2:0]     m_size;
   logic [1:0]     m_burst;
   logic [IDW-1:0] m_id;
   logic [1:0]     m_resp = 2'b00;
   bit             m_err = 1'b0;
   logic [DW-1:0]  beats [256];
   logic [SW-1:0]  strbs [256];
   int             n_aw_cyc, n_w_hs, n_wlast, n_done;

   always @(negedge clk) begin
      if (en) begin
         chk("cmd_ready", cmd_ready, ph == P_IDLE);
         chk("awvalid", m_axi_awvalid, ph == P_ADDR);
         if (ph == P_ADDR) begin
            n_aw_cyc++;
            chk("awaddr", m_axi_awaddr, m_addr);
            chk("awlen", m_axi_awlen, m_len);
            chk("awsize", m_axi_awsize, m_size);
            chk("awburst", m_axi_awburst, m_burst);
            chk("awid", m_axi_awid, m_id);
         end
         chk("wvalid", m_axi_wvalid, ph == P_DATA && wr_valid);
         chk("wr_ready", wr_ready, ph == P_DATA && m_axi_wready);
         chk("wlast", m_axi_wlast, ph == P_DATA && m_cnt == m_len);
         chk("bready", m_axi_bready, ph == P_RESP);
         chk("done", done, ph == P_DONE);
         chk("resp", resp, m_resp);
         chk("err", err, m_err);
         if (m_axi_wvalid && m_axi_wready && m_axi_wlast) n_wlast++;
         if (done) n_done++;

         if (rst) begin
            ph = P_IDLE; m_cnt = '0; m_resp = 2'b00; m_err = 1'b0;
         end else begin
            case (ph)
               P_IDLE: if (cmd_valid) begin
                  m_addr = cmd_addr; m_len = cmd_len; m_size = cmd_size;
                  m_burst = cmd_burst; m_id = cmd_id; ph = P_ADDR;
               end
               P_ADDR: if (m_axi_awready) begin
                  ph = P_DATA; m_cnt = '0;
               end
               P_DATA: if (wr_valid && m_axi_wready) begin
                  n_w_hs++;
                  chk("wdata_order", m_axi_wdata, beats[m_cnt]);
                  chk("wstrb_order", m_axi_wstrb, strbs[m_cnt]);
                  if (m_cnt == m_len) ph = P_RESP;
                  else m_cnt = m_cnt + 8'd1;
               end
               P_RESP: if (m_axi_bvalid) begin
                  m_resp = m_axi_bresp;
                  if (CHK && (m_axi_bresp != 2'b00 || m_axi_bid != m_id)) m_err = 1'b1;
                  ph = P_DONE;
               end
               default: ph = P_IDLE;
            endcase
         end
      end
   end

   // one burst; abort_at >= 0 applies reset after that many W handshakes
   task automatic run_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [IDW-1:0] id, input int aw_delay,
                            input bit toggle, input bit wrand,
                            input logic [1:0] br, input logic [IDW-1:0] bi,
                            input int abort_at, input bit b_early);
      bit hs;
      int c;
      int idx;
      for (int i = 0; i <= int'(len); i++) begin
         beats[i] = {$urandom, $urandom};
         strbs[i] = SW'($urandom);
      end
      n_aw_cyc = 0; n_w_hs = 0; n_wlast = 0; n_done = 0;
      cmd_addr = addr; cmd_len = len; cmd_size = 3'd3; cmd_burst = 2'b01;
      cmd_id = id; cmd_valid = 1'b1; m_axi_awready = (aw_delay == 0);
      c = 0;
      do begin
         #1 hs = cmd_ready;
         @(posedge clk); #1; c++;
      end while (!hs && c < 50);
      if (!hs) timeout("cmd");
      cmd_valid = 1'b0;
      c = 0;
      do begin
         m_axi_awready = (c >= aw_delay);
         if (b_early) begin m_axi_bvalid = 1'b1; m_axi_bresp = 2'b11; end
         #1 hs = m_axi_awvalid && m_axi_awready;
         @(posedge clk); #1; c++;
      end while (!hs && c < 50);
      if (!hs) timeout("aw");
      m_axi_awready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      idx = 0; c = 0;
      while (idx <= int'(len) && c < 2000) begin
         m_axi_wready = wrand ? 1'($urandom_range(0, 1)) : 1'b1;
         wr_valid = toggle ? (c % 2 == 0) : 1'b1;
         wr_data = beats[idx]; wr_strb = strbs[idx];
         #1 hs = wr_valid && wr_ready;
         @(posedge clk); #1; c++;
         if (hs) idx++;
         if (abort_at >= 0 && idx == abort_at) break;
      end
      wr_valid = 1'b0; m_axi_wready = 1'b1;
      if (abort_at >= 0) begin
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0; wr_valid = 1'b1; m_axi_awready = 1'b1;
         #1;
         chk("rst_cmd_ready", cmd_ready, 1'b1);
         chk("rst_awvalid", m_axi_awvalid, 1'b0);
         chk("rst_wvalid", m_axi_wvalid, 1'b0);
         chk("rst_wr_ready", wr_ready, 1'b0);
         chk("rst_awaddr", m_axi_awaddr, 32'h0);
         wr_valid = 1'b0; m_axi_awready = 1'b0;
         @(posedge clk); #1;
         return;
      end
      if (idx <= int'(len)) timeout("w");
      @(posedge clk); #1;
      m_axi_bvalid = 1'b1; m_axi_bresp = br; m_axi_bid = bi;
      c = 0;
      do begin
         #1 hs = m_axi_bready;
         @(posedge clk); #1; c++;
      end while (!hs && c < 50);
      if (!hs) timeout("b");
      m_axi_bvalid = 1'b0;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
      cmd_burst = '0; cmd_id = '0; wr_data = '0; wr_strb = '0; wr_valid = 1'b0;
      m_axi_awready = 1'b0; m_axi_wready = 1'b1; m_axi_bid = '0;
      m_axi_bresp = '0; m_axi_bvalid = 1'b0;
      @(posedge clk); #1;
      en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("reset_awaddr", m_axi_awaddr, 32'h0);
      chk("reset_awlen", m_axi_awlen, 8'h0);
      chk("reset_cmd_ready", cmd_ready, 1'b1);
      chk("reset_done", done, 1'b0);
      chk("reset_resp", resp, 2'b00);
      chk("reset_err", err, 1'b0);

      run_burst(32'h1000, 8'd3, 4'd2, 2, 1'b0, 1'b0, 2'b00, 4'd2, -1, 1'b0);
      chk("t1_aw_cycles", n_aw_cyc, 3);
      chk("t1_beats", n_w_hs, 4);
      chk("t1_wlast", n_wlast, 1);
      chk("t1_done", n_done, 1);
      chk("t1_resp", resp, 2'b00);

      run_burst(32'h2000, 8'd0, 4'd5, 0, 1'b0, 1'b0, 2'b00, 4'd5, -1, 1'b0);
      chk("t2_aw_cycles", n_aw_cyc, 1);
      chk("t2_beats", n_w_hs, 1);
      chk("t2_wlast", n_wlast, 1);
      chk("t2_done", n_done, 1);

      run_burst(32'h3000, 8'd7, 4'd1, 1, 1'b1, 1'b1, 2'b00, 4'd1, -1, 1'b1);
      chk("t3_beats", n_w_hs, 8);
      chk("t3_wlast", n_wlast, 1);
      chk("t3_done", n_done, 1);

      run_burst(32'h4000, 8'd3, 4'd6, 1, 1'b0, 1'b0, 2'b00, 4'd6, 2, 1'b0);
      chk("t4_beats", n_w_hs, 2);
      chk("t4_wlast", n_wlast, 0);
      chk("t4_done", n_done, 0);
      run_burst(32'h5000, 8'd3, 4'd7, 0, 1'b0, 1'b0, 2'b00, 4'd7, -1, 1'b0);
      chk("t4b_beats", n_w_hs, 4);
      chk("t4b_done", n_done, 1);

      run_burst(32'h6000, 8'd1, 4'd2, 0, 1'b0, 1'b0, 2'b10, 4'd2, -1, 1'b0);
      chk("t5_resp", resp, 2'b10);
      chk("t5_err", err, CHK);
      run_burst(32'h6100, 8'd2, 4'd2, 0, 1'b0, 1'b0, 2'b00, 4'd2, -1, 1'b0);
      chk("t5b_resp", resp, 2'b00);
      chk("t5b_err_sticky", err, CHK);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_err_cleared", err, 1'b0);
      run_burst(32'h6200, 8'd1, 4'd2, 0, 1'b0, 1'b0, 2'b00, 4'd3, -1, 1'b0);
      chk("t5c_resp", resp, 2'b00);
      chk("t5c_bid_err", err, CHK);

      run_burst(32'h8000, 8'd255, 4'd9, 0, 1'b0, 1'b0, 2'b00, 4'd9, -1, 1'b0);
      chk("t6_beats", n_w_hs, 256);
      chk("t6_wlast", n_wlast, 1);
      chk("t6_done", n_done, 1);

      repeat (2) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
